// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Level driven on the serial line whenever no frame is in flight.
  localparam logic TXD_IDLE = 1'b1;

  // Width of a 0..clkdiv-1 counter; never narrower than one bit.
  function automatic int div_width(input int clkdiv);
    return (clkdiv > 2) ? $clog2(clkdiv) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial/status outputs of the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: the transmitter pops only while fifo_empty is low.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             txd;
  logic             busy;
  logic [15:0]      nframes;

  // master: the transmitter; slave: the FIFO / line side
  modport master (
    input  fifo_data, fifo_empty,
    output fifo_pop, txd, busy, nframes
  );
  modport slave (
    output fifo_data, fifo_empty,
    input  fifo_pop, txd, busy, nframes
  );
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period divider: counts 0..CLKDIV-1 and flags the last cycle of each period.
// Latency: tick is combinational from the counter register.
// Backpressure: none; restart forces the next cycle to be cycle 0 of a period.
module baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int CLKDIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int DW = div_width(CLKDIV);
  localparam logic [DW-1:0] LAST = DW'(CLKDIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // Wrap at the end of each period, or realign when a new word is taken
  always_comb begin
    div_d = div_q + 1'b1;
    if (restart || (div_q == LAST)) begin
      div_d = '0;
    end
  end

  // Divider register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains an FWFT FIFO and serialises each word as start + LSB-first data + stop bits; optional even parity under FIFO_UART_TX_PARITY_EN.
// Latency: pop in the cycle fifo_empty is seen low while idle, start bit on the line the next cycle.
// Backpressure: pops only when fifo_empty=0, at most once per frame; back-to-back frames pop on the last stop cycle.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CLKDIV   = 16,
  parameter int STOPBITS = 1
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master bus
);

  localparam int IW = $clog2(WIDTH + 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              stop_q, stop_d;
  logic [15:0]       nframes_q, nframes_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif
  logic              tick;
  logic              last_stop;
  logic              pop;

  baud_tick #(.CLKDIV(CLKDIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (pop),
    .tick    (tick)
  );

  // A frame ends on the tick of its final stop-bit period; that cycle is also a pop opportunity
  assign last_stop = (state_q == STOP) && tick && (stop_q == 1'(STOPBITS - 1));
  assign pop       = reset && ((state_q == IDLE) || last_stop) && !bus.fifo_empty;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = START;
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick && (idx_q == IW'(WIDTH - 1))) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP:  if (last_stop) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: line level and status
  always_comb begin
    bus.txd = TXD_IDLE;
    case (state_q)
      START: bus.txd = 1'b0;
      DATA:  bus.txd = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: bus.txd = par_q;
`endif
      default: bus.txd = TXD_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.fifo_pop = pop;
  assign bus.nframes  = nframes_q;

  // Datapath next state: word capture, shifting, bit/stop counting, frame count
  always_comb begin
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_d    = stop_q;
    nframes_d = nframes_q + 16'(last_stop);
`ifdef FIFO_UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (pop) begin
      shift_d = bus.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = ^bus.fifo_data;
`endif
    end
    case (state_q)
      START: if (tick) idx_d = '0;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
        end
      end
      STOP: if (tick && !last_stop) stop_d = stop_q + 1'b1;
      default: ;
    endcase
    if ((state_d == STOP) && (state_q != STOP)) begin
      stop_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q     <= '0;
      shift_q   <= '0;
      stop_q    <= 1'b0;
      nframes_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      stop_q    <= stop_d;
      nframes_q <= nframes_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO model, line receiver and scoreboard of expected words.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_uart_tx;

  localparam int WIDTH    = 8;
  localparam int CLKDIV   = 4;
  localparam int STOPBITS = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int NBITS     = 1 + WIDTH + PBITS + STOPBITS;
  localparam int FRAME_CYC = NBITS * CLKDIV;

  typedef struct {
    int               start_cyc;
    logic [NBITS-1:0] bits;
    bit               glitch;
  } rx_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.WIDTH(WIDTH)) ifc ();

  fifo_uart_tx #(
    .WIDTH(WIDTH), .CLKDIV(CLKDIV), .STOPBITS(STOPBITS)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  rx_t              rx_q[$];
  int               pop_cyc_q[$];
  int               pop_cnt = 0;
  int               pop_empty_cnt = 0;
  int               cyc = 0;
  logic [15:0]      exp_nframes = 16'd0;

  // Expected line image of one word, index 0 = first bit on the wire
  function automatic logic [NBITS-1:0] frame_of(input logic [WIDTH-1:0] w);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[WIDTH:1] = w;
`ifdef FIFO_UART_TX_PARITY_EN
    f[WIDTH+1] = ^w;
`endif
    return f;
  endfunction

  // FWFT FIFO: the popped word leaves, and flags/data update, in the cycle after the pop
  always @(posedge clk) begin
    bit take;
    take = (ifc.fifo_pop === 1'b1);
    #1;
    if (take && fifo_q.size() > 0) void'(fifo_q.pop_front());
    ifc.fifo_empty = (fifo_q.size() == 0);
    ifc.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Line receiver: records every cycle of a frame, flags any level change within a bit period
  bit               rx_act = 1'b0;
  int               rx_cnt;
  int               rx_start;
  logic [NBITS-1:0] rx_bits;
  bit               rx_glitch;
  always @(negedge clk) begin
    int bi;
    rx_t rec;
    cyc++;
    if (ifc.fifo_pop === 1'b1) begin
      pop_cnt++;
      pop_cyc_q.push_back(cyc);
      if (ifc.fifo_empty !== 1'b0) pop_empty_cnt++;
    end
    if (rst_n !== 1'b1) begin
      rx_act = 1'b0;
    end else begin
      if (!rx_act && ifc.txd === 1'b0) begin
        rx_act = 1'b1; rx_cnt = 0; rx_start = cyc; rx_bits = '0; rx_glitch = 1'b0;
      end
      if (rx_act) begin
        bi = rx_cnt / CLKDIV;
        if (rx_cnt % CLKDIV == 0) rx_bits[bi] = ifc.txd;
        else if (ifc.txd !== rx_bits[bi]) rx_glitch = 1'b1;
        rx_cnt++;
        if (rx_cnt == FRAME_CYC) begin
          rec.start_cyc = rx_start; rec.bits = rx_bits; rec.glitch = rx_glitch;
          rx_q.push_back(rec);
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_rx(input int budget, output rx_t r, output bit got);
    got = 1'b0;
    r.start_cyc = -1; r.bits = 'x; r.glitch = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #2;
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        got = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.fifo_empty = 1'b1;
    ifc.fifo_data  = '0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", ifc.txd); end
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    checks++; if (ifc.fifo_pop !== 1'b0) begin failures++; $display("FAIL reset_pop: got %b want 0", ifc.fifo_pop); end
    checks++; if (ifc.nframes !== 16'd0) begin failures++; $display("FAIL reset_nframes: got %0d want 0", ifc.nframes); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    rx_t r; bit got; logic [WIDTH-1:0] e; int p0;
    @(negedge clk); #1;
    pop_cyc_q.delete();
    p0 = pop_cnt;
    push_word(8'hA5);
    wait_rx(200, r, got);
    checks++; if (!got) begin failures++; $display("FAIL single_timeout: got no frame want one"); end
    e = exp_q.pop_front(); exp_nframes++;
    checks++; if (r.bits !== frame_of(e)) begin failures++; $display("FAIL single_bits: got %b want %b", r.bits, frame_of(e)); end
    checks++; if (r.glitch) begin failures++; $display("FAIL single_hold: got level change inside a bit want none"); end
    repeat (3) @(negedge clk);
    checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL single_pops: got %0d want 1", pop_cnt - p0); end
    checks++; if (pop_cyc_q.size() != 1 || r.start_cyc != pop_cyc_q[0] + 1) begin
      failures++; $display("FAIL single_latency: got start %0d pops %0d want start one cycle after pop", r.start_cyc, pop_cyc_q.size()); end
    checks++; if (ifc.nframes !== exp_nframes) begin failures++; $display("FAIL single_nframes: got %0d want %0d", ifc.nframes, exp_nframes); end
    checks++; if (ifc.busy !== 1'b0 || ifc.txd !== 1'b1) begin failures++; $display("FAIL single_idle: got busy=%b txd=%b want 0/1", ifc.busy, ifc.txd); end
  endtask

  task automatic test_back_to_back();
    rx_t r1, r2; bit g1, g2; logic [WIDTH-1:0] e;
    @(negedge clk); #1;
    pop_cyc_q.delete();
    push_word(8'h00);
    push_word(8'hFF);
    wait_rx(200, r1, g1);
    wait_rx(200, r2, g2);
    checks++; if (!g1 || !g2) begin failures++; $display("FAIL b2b_timeout: got %0d%0d frames want 11", g1, g2); end
    e = exp_q.pop_front(); exp_nframes++;
    checks++; if (r1.bits !== frame_of(e)) begin failures++; $display("FAIL b2b_bits1: got %b want %b", r1.bits, frame_of(e)); end
    e = exp_q.pop_front(); exp_nframes++;
    checks++; if (r2.bits !== frame_of(e)) begin failures++; $display("FAIL b2b_bits2: got %b want %b", r2.bits, frame_of(e)); end
    checks++; if (r2.start_cyc - r1.start_cyc != FRAME_CYC) begin
      failures++; $display("FAIL b2b_gap: got spacing %0d want %0d", r2.start_cyc - r1.start_cyc, FRAME_CYC); end
    checks++; if (pop_cyc_q.size() != 2 || pop_cyc_q[1] != r1.start_cyc + FRAME_CYC - 1) begin
      failures++; $display("FAIL b2b_pop2: got pops %0d want second pop at cycle %0d", pop_cyc_q.size(), r1.start_cyc + FRAME_CYC - 1); end
    repeat (3) @(negedge clk);
    checks++; if (ifc.nframes !== exp_nframes) begin failures++; $display("FAIL b2b_nframes: got %0d want %0d", ifc.nframes, exp_nframes); end
  endtask

  task automatic test_idle();
    int bad_pop, bad_txd, bad_busy;
    bad_pop = 0; bad_txd = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ifc.fifo_pop !== 1'b0) bad_pop++;
      if (ifc.txd !== 1'b1) bad_txd++;
      if (ifc.busy !== 1'b0) bad_busy++;
    end
    checks++; if (bad_pop != 0) begin failures++; $display("FAIL idle_pop: got %0d pop cycles want 0", bad_pop); end
    checks++; if (bad_txd != 0) begin failures++; $display("FAIL idle_txd: got %0d low cycles want 0", bad_txd); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL idle_busy: got %0d busy cycles want 0", bad_busy); end
  endtask

  task automatic test_reset_mid();
    bit seen; int p0; int bad_txd; logic pre_txd;
    seen = 1'b0;
    @(negedge clk); #1;
    fifo_q.push_back(8'h5A);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (ifc.fifo_pop === 1'b1);
    end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_pop: got no pop want one"); end
    repeat (13) @(negedge clk);
    #2;
    pre_txd = ifc.txd;
    rst_n = 1'b0;
    #1;
    exp_nframes = 16'd0;
    checks++; if (pre_txd !== 1'b0 || ifc.txd !== 1'b1) begin
      failures++; $display("FAIL rmid_txd: got before=%b after=%b want 0/1", pre_txd, ifc.txd); end
    checks++; if (ifc.nframes !== 16'd0 || ifc.busy !== 1'b0) begin
      failures++; $display("FAIL rmid_clear: got nframes=%0d busy=%b want 0/0", ifc.nframes, ifc.busy); end
    repeat (3) @(negedge clk);
    p0 = pop_cnt;
    rst_n = 1'b1;
    bad_txd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifc.txd !== 1'b1) bad_txd++;
    end
    checks++; if (pop_cnt != p0) begin failures++; $display("FAIL rmid_nopop: got %0d pops want 0", pop_cnt - p0); end
    checks++; if (bad_txd != 0 || rx_q.size() != 0) begin
      failures++; $display("FAIL rmid_line: got %0d low cycles, %0d frames want 0/0", bad_txd, rx_q.size()); end
  endtask

  task automatic test_stream();
    rx_t r; bit got; logic [WIDTH-1:0] e; int bad;
    bad = 0;
    @(negedge clk); #1;
    for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom_range(0, 255)));
    for (int i = 0; i < 8; i++) begin
      wait_rx(200, r, got);
      e = exp_q.pop_front(); exp_nframes++;
      if (!got || r.glitch || r.bits !== frame_of(e)) begin
        bad++;
        $display("FAIL stream_frame%0d: got %b want %b", i, r.bits, frame_of(e));
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stream_total: got %0d bad frames want 0", bad); end
    repeat (3) @(negedge clk);
    checks++; if (ifc.nframes !== exp_nframes) begin failures++; $display("FAIL stream_nframes: got %0d want %0d", ifc.nframes, exp_nframes); end
  endtask

  task automatic test_wrap();
    rx_t r; bit got; logic [WIDTH-1:0] e;
    @(negedge clk);
    force dut.nframes_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.nframes_q;
    @(negedge clk);
    checks++; if (ifc.nframes !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload: got %h want ffff", ifc.nframes); end
    #1;
    push_word(8'h3C);
    wait_rx(200, r, got);
    e = exp_q.pop_front();
    checks++; if (!got || r.bits !== frame_of(e)) begin failures++; $display("FAIL wrap_bits: got %b want %b", r.bits, frame_of(e)); end
    repeat (3) @(negedge clk);
    checks++; if (ifc.nframes !== 16'h0000) begin failures++; $display("FAIL wrap_nframes: got %h want 0000", ifc.nframes); end
    exp_nframes = 16'h0000;
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    rx_t r1, r2; bit g1, g2;
    @(negedge clk); #1;
    push_word(8'h07);
    push_word(8'h03);
    wait_rx(200, r1, g1);
    wait_rx(200, r2, g2);
    void'(exp_q.pop_front()); void'(exp_q.pop_front());
    exp_nframes += 16'd2;
    checks++; if (!g1 || r1.bits[WIDTH+1] !== 1'b1 || r1.bits[WIDTH:1] !== 8'h07) begin
      failures++; $display("FAIL parity_07: got %b want parity 1", r1.bits); end
    checks++; if (!g2 || r2.bits[WIDTH+1] !== 1'b0 || r2.bits[WIDTH:1] !== 8'h03) begin
      failures++; $display("FAIL parity_03: got %b want parity 0", r2.bits); end
    checks++; if (r2.start_cyc - r1.start_cyc != 11 * CLKDIV || r1.bits[NBITS-1] !== 1'b1) begin
      failures++; $display("FAIL parity_len: got spacing %0d want %0d", r2.start_cyc - r1.start_cyc, 11 * CLKDIV); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    test_stream();
    test_wrap();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    checks++; if (exp_q.size() != 0 || rx_q.size() != 0) begin
      failures++; $display("FAIL leftovers: got exp=%0d rx=%0d want 0/0", exp_q.size(), rx_q.size()); end
    checks++; if (pop_empty_cnt != 0) begin failures++; $display("FAIL pop_on_empty: got %0d want 0", pop_empty_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
